// File: rtl/ex_mem_stage_if.sv
// ============================================================================
// Module      : ex_mem_stage_if
// Description : Valid/ready beat stream carrying one EX->MEM pipeline slot.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ex_mem_stage_if #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [63:0]       alu_result;
  logic              zero;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              mem_to_reg;
  logic              hilo_write;
  logic [REG_W-1:0]  write_reg;
  logic [DATA_W-1:0] store_data;

  modport master (
    output valid, alu_result, zero, reg_write, mem_read, mem_write,
           mem_to_reg, hilo_write, write_reg, store_data,
    input  ready
  );

  modport slave (
    input  valid, alu_result, zero, reg_write, mem_read, mem_write,
           mem_to_reg, hilo_write, write_reg, store_data,
    output ready
  );
endinterface

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module      : ex_mem_stage
// Description : EX->MEM stage with two-entry skid buffer and retire-time HI/LO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  ex_mem_stage_if.slave          in_if,
  ex_mem_stage_if.master         out_if,
  input  wire logic              flush_i,
  output logic [DATA_W-1:0]      hi_o,
  output logic [DATA_W-1:0]      lo_o,
  output logic                   fwd_valid_o,
  output logic [REG_W-1:0]       fwd_reg_o,
  output logic [DATA_W-1:0]      fwd_data_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [63:0]       alu_result;
    logic              zero;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              hilo_write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] store_data;
  } beat_t;

  state_t            state_q, state_d;
  beat_t             h_q, h_d;
  beat_t             s_q, s_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] hi_q, lo_q;

  beat_t in_beat;
  logic  acc;
  logic  ret;
  logic  commit;

  assign in_beat = '{
    alu_result: in_if.alu_result,
    zero:       in_if.zero,
    reg_write:  in_if.reg_write,
    mem_read:   in_if.mem_read,
    mem_write:  in_if.mem_write,
    mem_to_reg: in_if.mem_to_reg,
    hilo_write: in_if.hilo_write,
    write_reg:  in_if.write_reg,
    store_data: in_if.store_data
  };

  assign acc    = in_if.valid & in_ready_q;
  assign ret    = out_valid_q & out_if.ready;
  assign commit = ret & h_q.hilo_write & ~flush_i;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          h_d     = in_beat;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && ret) begin
          h_d = in_beat;
        end else if (acc) begin
          s_d     = in_beat;
          state_d = ST_FULL;
        end else if (ret) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (ret) begin
          h_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops every beat in flight, including one being loaded this cycle.
    if (flush_i) begin
      state_d = ST_EMPTY;
      h_d     = h_q;
      s_d     = s_q;
    end
  end

  // Ready/valid are registered from next-state, so out_ready never reaches in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      h_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      s_q         <= s_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      if (commit) begin
        lo_q <= DATA_W'(h_q.alu_result[31:0]);
        hi_q <= DATA_W'(h_q.alu_result[63:32]);
      end
    end
  end

  assign in_if.ready       = in_ready_q;
  assign out_if.valid      = out_valid_q;
  assign out_if.alu_result = h_q.alu_result;
  assign out_if.zero       = h_q.zero;
  assign out_if.reg_write  = h_q.reg_write;
  assign out_if.mem_read   = h_q.mem_read;
  assign out_if.mem_write  = h_q.mem_write;
  assign out_if.mem_to_reg = h_q.mem_to_reg;
  assign out_if.hilo_write = h_q.hilo_write;
  assign out_if.write_reg  = h_q.write_reg;
  assign out_if.store_data = h_q.store_data;

  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign fwd_valid_o = out_valid_q & h_q.reg_write & (h_q.write_reg != '0);
  assign fwd_reg_o   = h_q.write_reg;
  assign fwd_data_o  = DATA_W'(h_q.alu_result[31:0]);

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Directed self-checking bench for ex_mem_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [DATA_W-1:0] hi, lo;
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_reg;
  logic [DATA_W-1:0] fwd_data;

  int checks = 0;
  int errors = 0;

  ex_mem_stage_if #(.REG_W(REG_W), .DATA_W(DATA_W)) in_if ();
  ex_mem_stage_if #(.REG_W(REG_W), .DATA_W(DATA_W)) out_if ();

  ex_mem_stage #(.REG_W(REG_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if       (in_if),
    .out_if      (out_if),
    .flush_i     (flush),
    .hi_o        (hi),
    .lo_o        (lo),
    .fwd_valid_o (fwd_valid),
    .fwd_reg_o   (fwd_reg),
    .fwd_data_o  (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [63:0] alu, input logic hl,
                      input logic rw, input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] sd);
    in_if.valid      = v;
    in_if.alu_result = alu;
    in_if.hilo_write = hl;
    in_if.reg_write  = rw;
    in_if.write_reg  = wr;
    in_if.store_data = sd;
    in_if.zero       = (alu[31:0] == 32'd0);
    in_if.mem_read   = 1'b0;
    in_if.mem_write  = sd[0];
    in_if.mem_to_reg = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    out_if.ready = 1'b0;
    beat(1'b0, 64'd0, 1'b0, 1'b0, '0, '0);
    #12;
    chk("rst_out_valid", 64'(out_if.valid), 64'd0);
    chk("rst_in_ready",  64'(in_if.ready),  64'd1);
    chk("rst_hi",        64'(hi),           64'd0);
    chk("rst_lo",        64'(lo),           64'd0);
    chk("rst_alu",       out_if.alu_result, 64'd0);
    rst_n = 1'b1;
    step();

    // Streaming with the sink always ready.
    out_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 64'h100 + 64'(i), 1'b0, 1'b1, REG_W'(i + 1), DATA_W'(32'hA0 + i));
      step();
      chk("strm_valid", 64'(out_if.valid),  64'd1);
      chk("strm_alu",   out_if.alu_result,  64'h100 + 64'(i));
      chk("strm_ready", 64'(in_if.ready),   64'd1);
    end
    chk("strm_wreg",  64'(out_if.write_reg),  64'd8);
    chk("strm_sdata", 64'(out_if.store_data), 64'hA7);
    chk("strm_mw",    64'(out_if.mem_write),  64'd1);
    chk("strm_zero",  64'(out_if.zero),       64'd0);
    beat(1'b0, 64'd0, 1'b0, 1'b0, '0, '0);
    step();
    chk("strm_drain", 64'(out_if.valid), 64'd0);

    // Backpressure fills the skid entry.
    out_if.ready = 1'b0;
    beat(1'b1, 64'h11, 1'b0, 1'b0, '0, '0);
    step();
    chk("bp_a_ready", 64'(in_if.ready), 64'd1);
    beat(1'b1, 64'h22, 1'b0, 1'b0, '0, '0);
    step();
    chk("bp_full_ready", 64'(in_if.ready),   64'd0);
    chk("bp_full_alu",   out_if.alu_result,  64'h11);
    beat(1'b0, 64'h0, 1'b0, 1'b0, '0, '0);
    step();
    chk("bp_hold_alu",   out_if.alu_result,  64'h11);
    chk("bp_hold_valid", 64'(out_if.valid),  64'd1);
    chk("bp_hold_zero",  64'(out_if.zero),   64'd0);
    out_if.ready = 1'b1;
    #1;
    chk("bp_rel_first", out_if.alu_result, 64'h11);
    step();
    chk("bp_rel_second", out_if.alu_result, 64'h22);
    chk("bp_rel_ready",  64'(in_if.ready),  64'd1);
    step();
    chk("bp_empty", 64'(out_if.valid), 64'd0);

    // Multiply result commits to HI/LO only on retire.
    out_if.ready = 1'b0;
    beat(1'b1, 64'h0000_0003_FFFF_FFFE, 1'b1, 1'b0, '0, '0);
    step();
    beat(1'b0, 64'h0, 1'b0, 1'b0, '0, '0);
    chk("mul_no_commit_hi", 64'(hi), 64'd0);
    chk("mul_no_commit_lo", 64'(lo), 64'd0);
    out_if.ready = 1'b1;
    step();
    chk("mul_hi", 64'(hi), 64'h3);
    chk("mul_lo", 64'(lo), 64'hFFFF_FFFE);

    // Flush in FULL with a HiLoWrite head retiring and an incoming beat.
    out_if.ready = 1'b0;
    beat(1'b1, 64'h0000_00AA_0000_00BB, 1'b1, 1'b0, '0, '0);
    step();
    beat(1'b1, 64'h33, 1'b0, 1'b0, '0, '0);
    step();
    chk("fl_full", 64'(in_if.ready), 64'd0);
    beat(1'b1, 64'h44, 1'b0, 1'b0, '0, '0);
    out_if.ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    beat(1'b0, 64'h0, 1'b0, 1'b0, '0, '0);
    chk("fl_valid", 64'(out_if.valid), 64'd0);
    chk("fl_ready", 64'(in_if.ready),  64'd1);
    chk("fl_hi",    64'(hi),           64'h3);
    chk("fl_lo",    64'(lo),           64'hFFFF_FFFE);
    step();
    chk("fl_dropped", 64'(out_if.valid), 64'd0);
    // Flush while accepting from EMPTY drops the new beat.
    beat(1'b1, 64'h55, 1'b1, 1'b0, '0, '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    beat(1'b0, 64'h0, 1'b0, 1'b0, '0, '0);
    chk("fl_acc_valid", 64'(out_if.valid), 64'd0);
    step();
    chk("fl_acc_hi", 64'(hi), 64'h3);

    // Forwarding.
    out_if.ready = 1'b0;
    beat(1'b1, 64'h1234, 1'b0, 1'b1, 5'd0, '0);
    step();
    chk("fwd_r0_valid", 64'(fwd_valid), 64'd0);
    out_if.ready = 1'b1;
    beat(1'b1, 64'hCAFE, 1'b0, 1'b1, 5'd8, '0);
    step();
    chk("fwd_valid", 64'(fwd_valid), 64'd1);
    chk("fwd_reg",   64'(fwd_reg),   64'd8);
    chk("fwd_data",  64'(fwd_data),  64'hCAFE);
    beat(1'b1, 64'hBEEF, 1'b0, 1'b0, 5'd8, '0);
    step();
    chk("fwd_norw", 64'(fwd_valid), 64'd0);
    beat(1'b0, 64'h0, 1'b0, 1'b0, '0, '0);
    step();
    chk("fwd_empty", 64'(fwd_valid), 64'd0);

    // Asynchronous reset while FULL.
    out_if.ready = 1'b0;
    beat(1'b1, 64'h66, 1'b0, 1'b0, '0, '0);
    step();
    beat(1'b1, 64'h77, 1'b0, 1'b0, '0, '0);
    step();
    beat(1'b0, 64'h0, 1'b0, 1'b0, '0, '0);
    chk("ar_full", 64'(in_if.ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_if.valid), 64'd0);
    chk("ar_ready", 64'(in_if.ready),  64'd1);
    chk("ar_hi",    64'(hi),           64'd0);
    chk("ar_lo",    64'(lo),           64'd0);
    chk("ar_alu",   out_if.alu_result, 64'd0);
    #1;
    rst_n = 1'b1;
    out_if.ready = 1'b1;
    step();
    chk("ar_after", 64'(out_if.valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
